// File: rtl/memory_top.sv
// memory_top: memory stage of the pipelined RV32I core.
// Holds the EX/MEM register, a byte-addressed little-endian data memory whose
// accesses occupy M for MEM_LATENCY cycles, load formatting and the MEM/WB
// register. StallMem_o freezes upstream stages while an access is in flight.
// Build option MEMORY_TOP_SUBWORD_EN: byte/halfword loads and stores; when it
// is undefined Funct3 is ignored and every access is a word at addr & ~3.
module memory_top #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_LATENCY   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ALUResultE_i,
  input  logic [DATA_WIDTH-1:0] WriteDataE_i,
  input  logic [DATA_WIDTH-1:0] PCPlus4E_i,
  input  logic [4:0]            RdE_i,
  input  logic [2:0]            Funct3E_i,
  input  logic                  RegWriteE_i,
  input  logic                  MemWriteE_i,
  input  logic [1:0]            ResultSrcE_i,
  output logic [DATA_WIDTH-1:0] ALUResultM_o,
  output logic [4:0]            RdM_o,
  output logic                  RegWriteM_o,
  output logic                  StallMem_o,
  output logic [DATA_WIDTH-1:0] ResultW_o,
  output logic [4:0]            RdW_o,
  output logic                  RegWriteW_o
);

  localparam int NB        = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(NB);
  localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              cnt_reg, cnt_next;

  logic [DATA_WIDTH-1:0]   alu_result_m_reg, write_data_m_reg, pc_plus4_m_reg;
  logic [4:0]              rd_m_reg;
  logic                    reg_write_m_reg, mem_write_m_reg;
  logic [1:0]              result_src_m_reg;

  logic [DATA_WIDTH-1:0]   result_w_reg;
  logic [4:0]              rd_w_reg;
  logic                    reg_write_w_reg;

  logic                    memop_m, stall;
  logic [ADDRESS_WIDTH-1:0] addr_m, word_addr, base_addr;
  logic [NB-1:0]           byte_en;
  logic [DATA_WIDTH-1:0]   load_word, load_data, result_m;

  // Data memory is deliberately not reset: contents survive rst.
  logic [7:0] mem [0:(2**ADDRESS_WIDTH)-1];

  assign memop_m   = (result_src_m_reg == 2'b01) || mem_write_m_reg;
  assign stall     = memop_m && (cnt_reg != LAST_CNT);
  assign addr_m    = alu_result_m_reg[ADDRESS_WIDTH-1:0];
  assign word_addr = {addr_m[ADDRESS_WIDTH-1:LANE_BITS], {LANE_BITS{1'b0}}};

`ifdef MEMORY_TOP_SUBWORD_EN
  logic [2:0] funct3_m_reg;

  // EX/MEM register: loads only while the M stage is not stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) funct3_m_reg <= '0;
    else if (!stall) funct3_m_reg <= Funct3E_i;
  end

  // Width decode: aligned base address and the byte lanes the access touches.
  always_comb begin
    base_addr = word_addr;
    byte_en   = '1;
    case (funct3_m_reg[1:0])
      2'b00: begin
        base_addr = addr_m;
        byte_en   = NB'(1);
      end
      2'b01: begin
        base_addr = {addr_m[ADDRESS_WIDTH-1:1], 1'b0};
        byte_en   = NB'(3);
      end
      default: begin
        base_addr = word_addr;
        byte_en   = '1;
      end
    endcase
  end

  // Load formatting: sign- or zero-extend byte/half, pass words through.
  always_comb begin
    load_data = load_word;
    case (funct3_m_reg)
      3'b000:  load_data = {{(DATA_WIDTH-8){load_word[7]}}, load_word[7:0]};
      3'b001:  load_data = {{(DATA_WIDTH-16){load_word[15]}}, load_word[15:0]};
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, load_word[7:0]};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, load_word[15:0]};
      default: load_data = load_word;
    endcase
  end
`else
  // Word-only build: access width and the low address bits play no part.
  logic unused_bits;
  assign unused_bits = ^{Funct3E_i, addr_m[LANE_BITS-1:0]};
  assign base_addr   = word_addr;
  assign byte_en     = '1;
  assign load_data   = load_word;
`endif

  // Read lanes: little-endian, lane addresses wrap modulo the memory size.
  // The read is combinational so that a one-cycle access can still land
  // in W on the next edge.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [ADDRESS_WIDTH-1:0] lane_addr;
      assign lane_addr = base_addr + ADDRESS_WIDTH'(gi);
      assign load_word[8*gi +: 8] = mem[lane_addr];
    end
  endgenerate

  // Store commit: exactly once, on the edge that ends the access.
  always_ff @(posedge clk) begin
    if (mem_write_m_reg && !stall) begin
      for (int i = 0; i < NB; i++) begin
        if (byte_en[i]) mem[base_addr + ADDRESS_WIDTH'(i)] <= write_data_m_reg[8*i +: 8];
      end
    end
  end

  // Writeback source select; encoding 11 falls back to the ALU result.
  always_comb begin
    case (result_src_m_reg)
      2'b01:   result_m = load_data;
      2'b10:   result_m = pc_plus4_m_reg;
      default: result_m = alu_result_m_reg;
    endcase
  end

  // EX/MEM register: captures E while not stalled, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result_m_reg <= '0;
      write_data_m_reg <= '0;
      pc_plus4_m_reg   <= '0;
      rd_m_reg         <= '0;
      reg_write_m_reg  <= 1'b0;
      mem_write_m_reg  <= 1'b0;
      result_src_m_reg <= '0;
    end else if (!stall) begin
      alu_result_m_reg <= ALUResultE_i;
      write_data_m_reg <= WriteDataE_i;
      pc_plus4_m_reg   <= PCPlus4E_i;
      rd_m_reg         <= RdE_i;
      reg_write_m_reg  <= RegWriteE_i;
      mem_write_m_reg  <= MemWriteE_i;
      result_src_m_reg <= ResultSrcE_i;
    end
  end

  // Access FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Access FSM: count stalled cycles, return to IDLE on the final cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (stall) begin
          state_next = WAIT;
          cnt_next   = 4'd1;
        end
      end
      WAIT: begin
        if (stall) begin
          cnt_next = cnt_reg + 4'd1;
        end else begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
    endcase
  end

  // MEM/WB register: a stalled cycle inserts a bubble, data fields hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_w_reg    <= '0;
      rd_w_reg        <= '0;
      reg_write_w_reg <= 1'b0;
    end else if (!stall) begin
      result_w_reg    <= result_m;
      rd_w_reg        <= rd_m_reg;
      reg_write_w_reg <= reg_write_m_reg;
    end else begin
      reg_write_w_reg <= 1'b0;
    end
  end

  assign ALUResultM_o = alu_result_m_reg;
  assign RdM_o        = rd_m_reg;
  assign RegWriteM_o  = reg_write_m_reg;
  assign StallMem_o   = stall;
  assign ResultW_o    = result_w_reg;
  assign RdW_o        = rd_w_reg;
  assign RegWriteW_o  = reg_write_w_reg;

endmodule

// File: tb/tb_memory_top.sv
// tb_memory_top: directed bench for memory_top. Four instances with
// MEM_LATENCY 1..4 share the E-stage inputs; each test paces itself on the
// stall output of the instance it is checking.
module tb_memory_top;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        rwe;
    logic        mwe;
    logic [1:0]  rsrc;
  } ein_t;

  typedef struct packed {
    ein_t        e;
    logic        es;
    logic        ew;
    logic        cw;
    logic [31:0] eres;
    logic [4:0]  erd;
  } vec_t;

`ifdef MEMORY_TOP_SUBWORD_EN
  localparam logic [31:0] EXP_LB  = 32'hFFFFFFA5;
  localparam logic [31:0] EXP_LBU = 32'h000000A5;
  localparam logic [31:0] EXP_LW  = 32'hA5000000;
`else
  localparam logic [31:0] EXP_LB  = 32'h000000A5;
  localparam logic [31:0] EXP_LBU = 32'h000000A5;
  localparam logic [31:0] EXP_LW  = 32'h000000A5;
`endif

  logic        clk, rst;
  logic [31:0] alu_e, wd_e, pc4_e;
  logic [4:0]  rd_e;
  logic [2:0]  f3_e;
  logic        rwe_e, mwe_e;
  logic [1:0]  rsrc_e;

  logic [31:0] alu_m [1:4];
  logic [31:0] res_w [1:4];
  logic [4:0]  rd_m  [1:4];
  logic [4:0]  rd_w  [1:4];
  logic [4:1]  rw_m, rw_w, stall_v;

  int total = 0;
  int bad   = 0;
  vec_t vt[$];

  genvar gi;
  generate
    for (gi = 1; gi <= 4; gi++) begin : g_dut
      memory_top #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .MEM_LATENCY(gi)) dut (
        .clk(clk), .rst(rst),
        .ALUResultE_i(alu_e), .WriteDataE_i(wd_e), .PCPlus4E_i(pc4_e),
        .RdE_i(rd_e), .Funct3E_i(f3_e), .RegWriteE_i(rwe_e),
        .MemWriteE_i(mwe_e), .ResultSrcE_i(rsrc_e),
        .ALUResultM_o(alu_m[gi]), .RdM_o(rd_m[gi]), .RegWriteM_o(rw_m[gi]),
        .StallMem_o(stall_v[gi]), .ResultW_o(res_w[gi]), .RdW_o(rd_w[gi]),
        .RegWriteW_o(rw_w[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic apply(input ein_t e);
    alu_e = e.alu; wd_e = e.wd; pc4_e = e.pc4; rd_e = e.rd;
    f3_e = e.f3; rwe_e = e.rwe; mwe_e = e.mwe; rsrc_e = e.rsrc;
  endtask

  function automatic ein_t e_nop();
    ein_t e;
    e = '0;
    return e;
  endfunction

  function automatic ein_t e_st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    ein_t e;
    e = '0; e.alu = a; e.wd = d; e.f3 = f; e.mwe = 1'b1;
    return e;
  endfunction

  function automatic ein_t e_ld(input logic [31:0] a, input logic [4:0] r, input logic [2:0] f);
    ein_t e;
    e = '0; e.alu = a; e.rd = r; e.f3 = f; e.rwe = 1'b1; e.rsrc = 2'b01;
    return e;
  endfunction

  function automatic ein_t e_alu(input logic [31:0] a, input logic [31:0] p,
                                 input logic [4:0] r, input logic [1:0] s);
    ein_t e;
    e = '0; e.alu = a; e.pc4 = p; e.rd = r; e.rwe = 1'b1; e.rsrc = s;
    return e;
  endfunction

  function automatic vec_t row(input ein_t e, input logic es, input logic ew, input logic cw,
                               input logic [31:0] res, input logic [4:0] rd);
    vec_t v;
    v.e = e; v.es = es; v.ew = ew; v.cw = cw; v.eres = res; v.erd = rd;
    return v;
  endfunction

  // Called at a negedge right after driving E: returns at the negedge that
  // follows the edge which captured the op into M of the chosen instance.
  task automatic issue(input int lat);
    logic rdy;
    for (int k = 0; k < 40; k++) begin
      rdy = !stall_v[lat];
      @(negedge clk);
      if (rdy) return;
    end
    total++;
    bad++;
    $display("FAIL issue_timeout: lat=%0d op still held after 40 cycles, required acceptance", lat);
  endtask

  initial begin
    logic [31:0] r32;
    ein_t rnd;
    logic exp_s [1:8];

    // ---------------- reset held with random inputs ----------------
    rst = 1'b1;
    apply(e_nop());
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      r32 = $urandom; rnd.alu = r32; r32 = $urandom; rnd.wd = r32;
      r32 = $urandom; rnd.pc4 = r32;
      r32 = $urandom; rnd.rd = r32[4:0]; rnd.f3 = r32[7:5]; rnd.rwe = r32[8];
      rnd.mwe = r32[9]; rnd.rsrc = r32[11:10];
      apply(rnd);
      #1;
      check($sformatf("reset_ctl_%0d", i), 32'({rd_w[2], rw_w, stall_v, rw_m, rd_m[2]}), 32'd0);
      check($sformatf("reset_res_%0d", i), res_w[2] | alu_m[2], 32'd0);
      $display("reset cycle %0d: stall=%b rw_w=%b", i, stall_v, rw_w);
    end
    @(negedge clk);
    rst = 1'b0;
    apply(e_alu(32'h0000ABCD, 32'h0, 5'd2, 2'b00));
    @(negedge clk);
    check("post_reset_w_empty", 32'({rw_w[2], stall_v[2]}), 32'd0);
    apply(e_nop());
    @(negedge clk);
    check("post_reset_res", res_w[2], 32'h0000ABCD);
    check("post_reset_rd_rw", 32'({rd_w[2], rw_w[2]}), 32'({5'd2, 1'b1}));
    $display("post reset alu op: res=%h rd=%0d", res_w[2], rd_w[2]);

    // ---------------- MEM_LATENCY=2 vector table ----------------
    vt.push_back(row(e_st(32'h10, 32'hDEADBEEF, 3'b010),     1'b0, 1'b0, 1'b0, 32'h0, 5'd0)); // 0
    vt.push_back(row(e_ld(32'h10, 5'd5, 3'b010),             1'b1, 1'b0, 1'b0, 32'h0, 5'd0)); // 1
    vt.push_back(row(e_ld(32'h10, 5'd5, 3'b010),             1'b0, 1'b0, 1'b0, 32'h0, 5'd0)); // 2
    vt.push_back(row(e_alu(32'h12345678, 32'h0, 5'd7, 2'b00), 1'b1, 1'b0, 1'b0, 32'h0, 5'd0)); // 3
    vt.push_back(row(e_alu(32'h12345678, 32'h0, 5'd7, 2'b00), 1'b0, 1'b0, 1'b0, 32'h0, 5'd0)); // 4
    vt.push_back(row(e_alu(32'hCAFE0000, 32'h7, 5'd9, 2'b11), 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 5'd5)); // 5
    vt.push_back(row(e_nop(),                                1'b0, 1'b1, 1'b1, 32'h12345678, 5'd7)); // 6
    vt.push_back(row(e_alu(32'h55, 32'h104, 5'd1, 2'b10),     1'b0, 1'b1, 1'b1, 32'hCAFE0000, 5'd9)); // 7
    vt.push_back(row(e_nop(),                                1'b0, 1'b0, 1'b1, 32'h0, 5'd0)); // 8
    vt.push_back(row(e_nop(),                                1'b0, 1'b1, 1'b1, 32'h104, 5'd1)); // 9
    vt.push_back(row(e_st(32'h10, 32'h0, 3'b010),            1'b0, 1'b0, 1'b0, 32'h0, 5'd0)); // 10
    vt.push_back(row(e_st(32'h13, 32'h000000A5, 3'b000),     1'b1, 1'b0, 1'b0, 32'h0, 5'd0)); // 11
    vt.push_back(row(e_st(32'h13, 32'h000000A5, 3'b000),     1'b0, 1'b0, 1'b0, 32'h0, 5'd0)); // 12
    vt.push_back(row(e_ld(32'h13, 5'd10, 3'b000),            1'b1, 1'b0, 1'b0, 32'h0, 5'd0)); // 13
    vt.push_back(row(e_ld(32'h13, 5'd10, 3'b000),            1'b0, 1'b0, 1'b0, 32'h0, 5'd0)); // 14
    vt.push_back(row(e_ld(32'h13, 5'd11, 3'b100),            1'b1, 1'b0, 1'b0, 32'h0, 5'd0)); // 15
    vt.push_back(row(e_ld(32'h13, 5'd11, 3'b100),            1'b0, 1'b0, 1'b0, 32'h0, 5'd0)); // 16
    vt.push_back(row(e_ld(32'h10, 5'd12, 3'b010),            1'b1, 1'b1, 1'b1, EXP_LB, 5'd10)); // 17
    vt.push_back(row(e_ld(32'h10, 5'd12, 3'b010),            1'b0, 1'b0, 1'b1, EXP_LB, 5'd10)); // 18
    vt.push_back(row(e_nop(),                                1'b1, 1'b1, 1'b1, EXP_LBU, 5'd11)); // 19
    vt.push_back(row(e_nop(),                                1'b0, 1'b0, 1'b0, 32'h0, 5'd0)); // 20
    vt.push_back(row(e_nop(),                                1'b0, 1'b1, 1'b1, EXP_LW, 5'd12)); // 21
    vt.push_back(row(e_nop(),                                1'b0, 1'b0, 1'b0, 32'h0, 5'd0)); // 22

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      check($sformatf("row%0d_stall", i), 32'(stall_v[2]), 32'(vt[i].es));
      check($sformatf("row%0d_rw_w", i), 32'(rw_w[2]), 32'(vt[i].ew));
      if (vt[i].cw) begin
        check($sformatf("row%0d_res_w", i), res_w[2], vt[i].eres);
        check($sformatf("row%0d_rd_w", i), 32'(rd_w[2]), 32'(vt[i].erd));
      end
      apply(vt[i].e);
      $display("row %0d: stall=%0b rw_w=%0b res_w=%h rd_w=%0d", i, stall_v[2], rw_w[2], res_w[2], rd_w[2]);
    end

    // ---------------- MEM_LATENCY=1, address wrap ----------------
    @(negedge clk);
    apply(e_st(32'h130, 32'h5A5A5A5A, 3'b010));
    @(negedge clk);
    check("lat1_store_no_stall", 32'(stall_v[1]), 32'd0);
    apply(e_ld(32'h30, 5'd8, 3'b010));
    @(negedge clk);
    check("lat1_load_no_stall", 32'(stall_v[1]), 32'd0);
    check("lat1_store_no_wb", 32'(rw_w[1]), 32'd0);
    apply(e_nop());
    @(negedge clk);
    check("lat1_load_res", res_w[1], 32'h5A5A5A5A);
    check("lat1_load_rd_rw", 32'({rd_w[1], rw_w[1]}), 32'({5'd8, 1'b1}));
    $display("lat1 wrap load: res=%h rd=%0d rw=%0b", res_w[1], rd_w[1], rw_w[1]);

    // ---------------- MEM_LATENCY=3 back-to-back loads ----------------
    apply(e_st(32'h10, 32'h11112222, 3'b010)); issue(3);
    apply(e_st(32'h14, 32'h33334444, 3'b010)); issue(3);
    apply(e_nop());                            issue(3);
    exp_s = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    apply(e_ld(32'h10, 5'd3, 3'b010));
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check($sformatf("b2b_stall_%0d", i), 32'(stall_v[3]), 32'(exp_s[i]));
      check($sformatf("b2b_rw_%0d", i), 32'(rw_w[3]), 32'((i == 4) || (i == 7)));
      if (i == 4) begin
        check("b2b_first_res", res_w[3], 32'h11112222);
        check("b2b_first_rd", 32'(rd_w[3]), 32'd3);
      end
      if (i == 7) begin
        check("b2b_second_res", res_w[3], 32'h33334444);
        check("b2b_second_rd", 32'(rd_w[3]), 32'd4);
      end
      if (i == 1) apply(e_ld(32'h14, 5'd4, 3'b010));
      if (i == 4) apply(e_nop());
      $display("b2b cycle %0d: stall=%0b rw_w=%0b res_w=%h", i, stall_v[3], rw_w[3], res_w[3]);
    end

    // ---------------- MEM_LATENCY=4 reset during store stall ----------------
    apply(e_st(32'h20, 32'h11111111, 3'b010)); issue(4);
    apply(e_nop());                            issue(4);
    apply(e_st(32'h20, 32'h22222222, 3'b010));
    @(negedge clk);
    check("rst_mid_stall1", 32'(stall_v[4]), 32'd1);
    apply(e_nop());
    @(negedge clk);
    check("rst_mid_stall2", 32'(stall_v[4]), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_cleared", 32'({stall_v[4], rw_w[4], rw_m[4]}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    $display("reset pulsed during store stall");
    apply(e_ld(32'h20, 5'd6, 3'b010));
    issue(4);
    apply(e_nop());
    for (int j = 0; j < 4; j++) begin
      check($sformatf("lat4_load_stall_%0d", j), 32'(stall_v[4]), 32'(j < 3));
      check($sformatf("lat4_load_nowb_%0d", j), 32'(rw_w[4]), 32'd0);
      @(negedge clk);
    end
    check("lat4_load_res", res_w[4], 32'h11111111);
    check("lat4_load_rd_rw", 32'({rd_w[4], rw_w[4]}), 32'({5'd6, 1'b1}));
    $display("lat4 load after reset: res=%h rd=%0d rw=%0b", res_w[4], rd_w[4], rw_w[4]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
